// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch run-control sequencer and its
// surroundings: raw board buttons in, counter/display controls out.
// The master side is the sequencer; the slave side is the board/counter path.
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lap;
    logic       btn_rst;
    logic       tick;
    logic       cnt_clr;
    logic       freeze;
    logic [1:0] state;

    modport master (
        input  btn_ss,
        input  btn_lap,
        input  btn_rst,
        output tick,
        output cnt_clr,
        output freeze,
        output state
    );

    modport slave (
        output btn_ss,
        output btn_lap,
        output btn_rst,
        input  tick,
        input  cnt_clr,
        input  freeze,
        input  state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run-control sequencer for the tenth-second stopwatch.
// Debounces the start/stop, reset and (optionally) lap buttons, runs the
// IDLE/RUN/PAUSE/LAP state machine and generates the tenth-second tick.
// Optional lap feature: define STOPWATCH_CTRL_LAP_EN to build the lap
// debouncer and the LAP state; without it freeze is tied low and lap is unused.
module stopwatch_ctrl #(
    parameter int DIV       = 10_000_000,
    parameter int DB_CYCLES = 500_000
) (
    input  logic             clk,
    input  logic             clr,
    stopwatch_ctrl_if.master bus
);

    localparam int PW  = $clog2(DIV);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);

    localparam int B_SS  = 0;
    localparam int B_RST = 1;
`ifdef STOPWATCH_CTRL_LAP_EN
    localparam int B_LAP = 2;
    localparam int NBTN  = 3;
`else
    localparam int NBTN  = 2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    // Button path: raw levels, two-stage synchronizer, accepted level,
    // its one-cycle-delayed copy for edge detection, and press pulses.
    logic [NBTN-1:0] raw_s;
    logic [NBTN-1:0] sync1_r;
    logic [NBTN-1:0] sync2_r;
    logic [NBTN-1:0] acc_r;
    logic [NBTN-1:0] acc_prev_r;
    logic [NBTN-1:0] press_r;
    logic [DBW-1:0]  db_cnt_r [NBTN];

    // Arbitrated events (rst beats ss beats lap)
    logic rst_ev_s;
    logic ss_ev_s;
`ifdef STOPWATCH_CTRL_LAP_EN
    logic lap_ev_s;
    logic freeze_s;
    logic freeze_r;
`endif

    state_t         state_r;
    state_t         state_nxt_s;
    logic           cnt_clr_s;
    logic           cnt_clr_r;
    logic           tick_r;
    logic           running_s;
    logic [PW-1:0]  presc_r;

`ifdef STOPWATCH_CTRL_LAP_EN
    assign raw_s = {bus.btn_lap, bus.btn_rst, bus.btn_ss};
`else
    assign raw_s = {bus.btn_rst, bus.btn_ss};
`endif

    // Synchronize, debounce and edge-detect every button; a press is a 0->1 of the accepted level
    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_r    <= '0;
            sync2_r    <= '0;
            acc_r      <= '0;
            acc_prev_r <= '0;
            press_r    <= '0;
            for (int b = 0; b < NBTN; b++) begin
                db_cnt_r[b] <= '0;
            end
        end else begin
            sync1_r    <= raw_s;
            sync2_r    <= sync1_r;
            acc_prev_r <= acc_r;
            press_r    <= acc_r & ~acc_prev_r;
            for (int b = 0; b < NBTN; b++) begin
                if (sync2_r[b] == acc_r[b]) begin
                    db_cnt_r[b] <= '0;
                end else if (db_cnt_r[b] == DB_LAST) begin
                    acc_r[b]    <= ~acc_r[b];
                    db_cnt_r[b] <= '0;
                end else begin
                    db_cnt_r[b] <= db_cnt_r[b] + DBW'(1'b1);
                end
            end
        end
    end

    // Resolve simultaneous presses so that only the highest-priority one acts
    always_comb begin
        rst_ev_s = press_r[B_RST];
        ss_ev_s  = press_r[B_SS] & ~press_r[B_RST];
`ifdef STOPWATCH_CTRL_LAP_EN
        lap_ev_s = press_r[B_LAP] & ~press_r[B_SS] & ~press_r[B_RST];
`endif
    end

    // Next-state and next-output decode of the run-control state machine
    always_comb begin
        state_nxt_s = state_r;
        cnt_clr_s   = 1'b0;
`ifdef STOPWATCH_CTRL_LAP_EN
        freeze_s    = freeze_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (ss_ev_s) begin
                    state_nxt_s = ST_RUN;
                end else if (rst_ev_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ss_ev_s) begin
                    state_nxt_s = ST_PAUSE;
`ifdef STOPWATCH_CTRL_LAP_EN
                end else if (lap_ev_s) begin
                    state_nxt_s = ST_LAP;
                    freeze_s    = 1'b1;
`endif
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (ss_ev_s) begin
                    state_nxt_s = ST_RUN;
                end else if (rst_ev_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_LAP: begin
`ifdef STOPWATCH_CTRL_LAP_EN
                if (ss_ev_s) begin
                    state_nxt_s = ST_PAUSE;
                    freeze_s    = 1'b0;
                end else if (lap_ev_s) begin
                    state_nxt_s = ST_RUN;
                    freeze_s    = 1'b0;
                end else begin
                    state_nxt_s = ST_LAP;
                end
`else
                // Unreachable without the lap feature; recover to a safe state
                state_nxt_s = ST_IDLE;
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // The prescaler advances only while time is running
    assign running_s = (state_r == ST_RUN) || (state_r == ST_LAP);

    // State register, registered control outputs and the tenth-second prescaler
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r   <= ST_IDLE;
            cnt_clr_r <= 1'b1;
            tick_r    <= 1'b0;
            presc_r   <= '0;
`ifdef STOPWATCH_CTRL_LAP_EN
            freeze_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            cnt_clr_r <= cnt_clr_s;
`ifdef STOPWATCH_CTRL_LAP_EN
            freeze_r  <= freeze_s;
`endif
            // Tick follows the wrap even if a stop press lands in the same cycle
            tick_r    <= running_s && (presc_r == PRESC_LAST);
            if (cnt_clr_s) begin
                presc_r <= '0;
            end else if (running_s) begin
                if (presc_r == PRESC_LAST) begin
                    presc_r <= '0;
                end else begin
                    presc_r <= presc_r + PW'(1'b1);
                end
            end else begin
                presc_r <= presc_r;
            end
        end
    end

    assign bus.state   = state_r;
    assign bus.tick    = tick_r;
    assign bus.cnt_clr = cnt_clr_r;
`ifdef STOPWATCH_CTRL_LAP_EN
    assign bus.freeze  = freeze_r;
`else
    assign bus.freeze  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DIV=4, DB_CYCLES=3.
// Stimulus pushes hand-computed records {cycle, state, freeze, tick, cnt_clr}
// for every cycle where something visible happens; the monitor records every
// cycle with a tick, a cnt_clr, or a state/freeze change and compares in order.
module tb_stopwatch_ctrl;

    typedef struct packed {
        int         cyc;
        logic [1:0] st;
        logic       fz;
        logic       tk;
        logic       cc;
    } rec_t;

    logic clk = 1'b0;
    logic clr;
    int   ecnt = 0;
    int   checks = 0;
    int   errors = 0;
    logic done = 1'b0;
    logic fin  = 1'b0;
    logic [1:0] prev_st = 2'b00;
    logic       prev_fz = 1'b0;
    rec_t exp_q [$];
    rec_t act_m;
    rec_t exp_m;
    int   c, e, g, i, j, m, n;

    stopwatch_ctrl_if sw ();

    stopwatch_ctrl #(
        .DIV       (4),
        .DB_CYCLES (3)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (sw)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic at(input int t);
        while (ecnt < t) @(negedge clk);
    endtask

    function automatic void expect_rec(input int cyc, input logic [1:0] st,
                                       input logic fz, input logic tk, input logic cc);
        rec_t r;
        r.cyc = cyc;
        r.st  = st;
        r.fz  = fz;
        r.tk  = tk;
        r.cc  = cc;
        exp_q.push_back(r);
    endfunction

    // Monitor: record notable cycles and check them against the scoreboard queue
    always @(negedge clk) begin
        if (done) begin
            if (!fin) begin
                checks <= checks + 1;
                if (exp_q.size() != 0) begin
                    errors <= errors + 1;
                    $display("FAIL leftover: %0d expected records never seen, next cyc=%0d",
                             exp_q.size(), exp_q[0].cyc);
                end
                fin <= 1'b1;
            end
        end else if ((sw.tick !== 1'b0) || (sw.cnt_clr !== 1'b0) ||
                     (sw.state !== prev_st) || (sw.freeze !== prev_fz)) begin
            act_m = '{ecnt, sw.state, sw.freeze, sw.tick, sw.cnt_clr};
            checks <= checks + 1;
            if (exp_q.size() == 0) begin
                errors <= errors + 1;
                $display("FAIL unexpected: cyc=%0d state=%b freeze=%b tick=%b cnt_clr=%b, required nothing",
                         act_m.cyc, act_m.st, act_m.fz, act_m.tk, act_m.cc);
            end else begin
                exp_m = exp_q.pop_front();
                if (act_m !== exp_m) begin
                    errors <= errors + 1;
                    $display("FAIL record: got cyc=%0d state=%b freeze=%b tick=%b cnt_clr=%b, required cyc=%0d state=%b freeze=%b tick=%b cnt_clr=%b",
                             act_m.cyc, act_m.st, act_m.fz, act_m.tk, act_m.cc,
                             exp_m.cyc, exp_m.st, exp_m.fz, exp_m.tk, exp_m.cc);
                end
            end
        end
        prev_st <= sw.state;
        prev_fz <= sw.freeze;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        clr        = 1'b1;
        sw.btn_ss  = 1'b0;
        sw.btn_lap = 1'b0;
        sw.btn_rst = 1'b0;

        // Reset held for two edges: IDLE, no tick/freeze, cnt_clr high; low after release
        expect_rec(1, 2'b00, 1'b0, 1'b0, 1'b1);
        expect_rec(2, 2'b00, 1'b0, 1'b0, 1'b1);
        at(2);
        clr = 1'b0;

        // Start (held 10 cycles), rst press while running ignored, then pause after a tick
        c = 6;
        expect_rec(c + 7,  2'b01, 1'b0, 1'b0, 1'b0);
        expect_rec(c + 11, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(c + 15, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(c + 19, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(c + 23, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(c + 24, 2'b10, 1'b0, 1'b0, 1'b0);
        at(c);      sw.btn_ss  = 1'b1;
        at(c + 4);  sw.btn_rst = 1'b1;
        at(c + 9);  sw.btn_rst = 1'b0;
        at(c + 10); sw.btn_ss  = 1'b0;
        at(c + 17); sw.btn_ss  = 1'b1;
        at(c + 22); sw.btn_ss  = 1'b0;

        // Resume with prescaler at 1: first tick 3 cycles after RUN; pause again
        e = c + 30;
        expect_rec(e + 7,  2'b01, 1'b0, 1'b0, 1'b0);
        expect_rec(e + 10, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(e + 14, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(e + 18, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(e + 19, 2'b10, 1'b0, 1'b0, 1'b0);
        at(e);      sw.btn_ss = 1'b1;
        at(e + 5);  sw.btn_ss = 1'b0;
        at(e + 12); sw.btn_ss = 1'b1;
        at(e + 17); sw.btn_ss = 1'b0;

        // Bounce every 2 cycles for 12 cycles: nothing; then a clean hold resumes once
        g = e + 30;
        expect_rec(g + 19, 2'b01, 1'b0, 1'b0, 1'b0);
        expect_rec(g + 22, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(g + 26, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(g + 30, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(g + 31, 2'b10, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            at(g + k);
            sw.btn_ss = ((k % 4) < 2) ? 1'b1 : 1'b0;
        end
        at(g + 12); sw.btn_ss = 1'b1;
        at(g + 17); sw.btn_ss = 1'b0;
        at(g + 24); sw.btn_ss = 1'b1;
        at(g + 29); sw.btn_ss = 1'b0;

        // Reset from PAUSE: IDLE with one cnt_clr; restart ticks 4 cycles after RUN
        i = g + 40;
        expect_rec(i + 7, 2'b00, 1'b0, 1'b0, 1'b1);
        at(i);     sw.btn_rst = 1'b1;
        at(i + 5); sw.btn_rst = 1'b0;
        j = i + 12;
        expect_rec(j + 7,  2'b01, 1'b0, 1'b0, 1'b0);
        expect_rec(j + 11, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(j + 15, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(j + 19, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(j + 21, 2'b10, 1'b0, 1'b0, 1'b0);
        at(j);      sw.btn_ss = 1'b1;
        at(j + 5);  sw.btn_ss = 1'b0;
        at(j + 14); sw.btn_ss = 1'b1;
        at(j + 19); sw.btn_ss = 1'b0;

        // rst and ss together in PAUSE: rst wins, back to IDLE
        m = j + 30;
        expect_rec(m + 7, 2'b00, 1'b0, 1'b0, 1'b1);
        at(m);     sw.btn_ss = 1'b1; sw.btn_rst = 1'b1;
        at(m + 5); sw.btn_ss = 1'b0; sw.btn_rst = 1'b0;

        // Lap in RUN: freeze with ticks continuing, second lap returns to RUN
        n = m + 16;
        expect_rec(n + 7,  2'b01, 1'b0, 1'b0, 1'b0);
        expect_rec(n + 11, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(n + 15, 2'b01, 1'b0, 1'b1, 1'b0);
`ifdef STOPWATCH_CTRL_LAP_EN
        expect_rec(n + 16, 2'b11, 1'b1, 1'b0, 1'b0);
        expect_rec(n + 19, 2'b11, 1'b1, 1'b1, 1'b0);
        expect_rec(n + 23, 2'b11, 1'b1, 1'b1, 1'b0);
`else
        expect_rec(n + 19, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(n + 23, 2'b01, 1'b0, 1'b1, 1'b0);
`endif
        expect_rec(n + 27, 2'b01, 1'b0, 1'b1, 1'b0);
        expect_rec(n + 31, 2'b01, 1'b0, 1'b1, 1'b0);
        at(n);      sw.btn_ss  = 1'b1;
        at(n + 5);  sw.btn_ss  = 1'b0;
        at(n + 9);  sw.btn_lap = 1'b1;
        at(n + 14); sw.btn_lap = 1'b0;
        at(n + 20); sw.btn_lap = 1'b1;
        at(n + 25); sw.btn_lap = 1'b0;
        at(n + 33);
        @(posedge clk);
        done = 1'b1;

        repeat (10) begin
            if (!fin) @(negedge clk);
        end
        #1;
        if (!fin) begin
            $display("FAIL final: scoreboard did not close");
            $fatal(1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
